mem_resp_stage: RTL

//  MEM pipeline stage directly downstream of exe_stage; consumes es_to_ms_bus and the data-SRAM

---
 rtl/mem_resp_stage_if.sv | 25 ++
 rtl/mem_resp_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_resp_stage_if.sv
// Handshake and bus bundle around the MEM response stage: EXE->MEM, MEM->WB and data-SRAM response.
// The stage itself uses the slave modport; the surrounding pipeline/bench drives the master side.
interface mem_resp_stage_if;
    logic        flush;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [96:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [86:0] ms_to_ws_bus;
    logic [9:0]  stall_ms_bus;
    logic [32:0] forward_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stall_ms_bus, forward_ms_bus
    );

    modport slave (
        input  flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, stall_ms_bus, forward_ms_bus
    );
endinterface

// File: rtl/mem_resp_stage.sv
// MEM stage: waits for data_ok, buffers early read data, extracts loads and drops stale responses.
// Define MS_LOAD_FWD_EN to forward load results in the cycle their data is available.
module mem_resp_stage #(
    parameter int unsigned DISC_WD = 2
) (
    input logic             clk,
    input logic             resetn,
    mem_resp_stage_if.slave bus
);
    logic               ms_valid;
    logic [96:0]        ms_bus_r;
    logic               buf_valid;
    logic [31:0]        rdata_buf;
    logic [DISC_WD-1:0] disc_cnt;
    logic [DISC_WD-1:0] disc_d;

    logic        mem_req;
    logic        bd;
    logic        exc_sys;
    logic        eret_flush;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic [6:0]  inst_load;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        unused_ld_extd;

    assign {mem_req, bd, exc_sys, eret_flush, cp0_wen, res_from_cp0, cp0_addr, res_from_mem,
            inst_load} = ms_bus_r[96:75];
    assign gr_we      = ms_bus_r[69];
    assign dest       = ms_bus_r[68:64];
    assign alu_result = ms_bus_r[63:32];
    assign pc         = ms_bus_r[31:0];
    // Extension op is consumed further down the pipe.
    assign unused_ld_extd = ^ms_bus_r[74:70];

    logic own_ok;
    logic ms_ready_go;
    logic ms_allowin;
    logic ms_to_ws_valid;
    logic handoff;
    logic buf_load;
    logic kill_ms;
    logic kill_es;
    logic disc_dec;

    assign own_ok         = bus.data_sram_data_ok && (disc_cnt == '0);
    assign ms_ready_go    = !mem_req || buf_valid || own_ok;
    assign ms_allowin     = !ms_valid || (ms_ready_go && bus.ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign handoff        = ms_to_ws_valid && bus.ws_allowin;
    assign buf_load       = ms_valid && mem_req && !buf_valid && own_ok && !bus.ws_allowin;

    // A flushed access whose response is still in flight must have that response swallowed later.
    assign kill_ms  = bus.flush && ms_valid && mem_req && !buf_valid && !own_ok;
    assign kill_es  = bus.flush && bus.es_to_ms_valid && bus.es_to_ms_bus[96];
    assign disc_dec = bus.data_sram_data_ok && (disc_cnt != '0);
    assign disc_d   = disc_cnt + DISC_WD'(kill_ms) + DISC_WD'(kill_es) - DISC_WD'(disc_dec);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            ms_bus_r  <= '0;
            buf_valid <= 1'b0;
            rdata_buf <= '0;
            disc_cnt  <= '0;
        end else begin
            disc_cnt <= disc_d;
            if (bus.flush) begin
                ms_valid  <= 1'b0;
                buf_valid <= 1'b0;
            end else begin
                if (ms_allowin) begin
                    ms_valid <= bus.es_to_ms_valid;
                end
                if (ms_allowin && bus.es_to_ms_valid) begin
                    ms_bus_r <= bus.es_to_ms_bus;
                end
                if (handoff) begin
                    buf_valid <= 1'b0;
                end else if (buf_load) begin
                    buf_valid <= 1'b1;
                    rdata_buf <= bus.data_sram_rdata;
                end
            end
        end
    end

    logic [31:0] ld_data;
    logic [1:0]  a;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [3:0]  rf_wstrb;
    logic [31:0] final_result;

    assign ld_data = buf_valid ? rdata_buf : bus.data_sram_rdata;
    assign a       = alu_result[1:0];
    assign ld_byte = ld_data[{a, 3'b000} +: 8];
    assign ld_half = a[1] ? ld_data[31:16] : ld_data[15:0];

    // inst_load is one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}; all-zero for non-loads.
    always_comb begin
        load_val = ld_data;
        rf_wstrb = 4'b1111;
        unique case (inst_load)
            7'b1000000: load_val = {{24{ld_byte[7]}}, ld_byte};
            7'b0100000: load_val = {24'h0, ld_byte};
            7'b0010000: load_val = {{16{ld_half[15]}}, ld_half};
            7'b0001000: load_val = {16'h0, ld_half};
            7'b0000100: load_val = ld_data;
            7'b0000010: begin
                load_val = ld_data << {~a, 3'b000};
                rf_wstrb = 4'b1111 << ~a;
            end
            7'b0000001: begin
                load_val = ld_data >> {a, 3'b000};
                rf_wstrb = 4'b1111 >> a;
            end
            default: ;
        endcase
    end

    assign final_result = res_from_mem ? load_val : alu_result;

    logic fwd_valid;
`ifdef MS_LOAD_FWD_EN
    assign fwd_valid = ms_valid && !res_from_cp0 && (!res_from_mem || buf_valid || own_ok);
`else
    assign fwd_valid = ms_valid && !res_from_mem && !res_from_cp0;
`endif

    assign bus.ms_allowin     = ms_allowin;
    assign bus.ms_to_ws_valid = ms_to_ws_valid;
    assign bus.ms_to_ws_bus   = {bd, exc_sys, eret_flush, cp0_wen, res_from_cp0, cp0_addr, gr_we,
                                 rf_wstrb, dest, final_result, pc};
    assign bus.stall_ms_bus   = {{5{ms_valid & gr_we}}, dest};
    assign bus.forward_ms_bus = {fwd_valid, final_result};
endmodule
